// File: rtl/cmd_queue_producer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_queue_producer
//  Purpose  : Pushes 128-bit commands into a submission-queue ring over an
//             AXI4-Lite master (4 word writes + tail doorbell) and refreshes
//             the consumer head pointer on each rising edge of irq_cq.
//  Options  : CMD_QUEUE_PRODUCER_ERR_CNT_EN - enables the saturating err_count
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_queue_producer #(
  parameter int                        C_M_ADDR_WIDTH = 12,
  parameter logic [C_M_ADDR_WIDTH-1:0] C_SQ_BASE      = 12'h100,
  parameter int                        C_SQ_DEPTH     = 16,
  parameter logic [C_M_ADDR_WIDTH-1:0] C_SQ_TAIL_ADDR = 12'h000,
  parameter logic [C_M_ADDR_WIDTH-1:0] C_SQ_HEAD_ADDR = 12'h004,
  localparam int                       P              = $clog2(C_SQ_DEPTH) + 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [127:0]              cmd_data,
  output logic [C_M_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [C_M_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic                      irq_cq,
  output logic                      sq_full,
  output logic [P-1:0]              sq_level,
  output logic                      err,
  output logic [7:0]                err_count
);

  localparam int          AW      = C_M_ADDR_WIDTH;
  localparam logic [P-1:0] DEPTH_P = P'(C_SQ_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SLOT  = 3'd1,
    WR_RESP  = 3'd2,
    DOORBELL = 3'd3,
    DB_RESP  = 3'd4,
    HEAD_AR  = 3'd5,
    HEAD_R   = 3'd6
  } state_t;

  state_t         r_state;
  logic [P-1:0]   r_tail;
  logic [P-1:0]   r_head;
  logic [1:0]     r_idx;
  logic [127:0]   r_cmd;
  logic           r_irq_q;
  logic           r_head_pend;
  logic           r_err;
  logic           r_rdy_en;

  logic           w_irq_edge;
  logic [P-1:0]   w_tail_nxt;
  logic [1:0]     w_idx_nxt;
  logic [AW-1:0]  w_slot_base;
  logic [P-1:0]   w_new_head;
  logic [P-1:0]   w_new_level;
  logic           w_r_fire;
  logic           w_bad_b;
  logic           w_bad_r;
  logic           w_bad_head;
  logic           w_aw_done;
  logic           w_w_done;
  logic           w_unused_rdata;

  assign w_irq_edge  = irq_cq & ~r_irq_q;
  assign w_tail_nxt  = r_tail + 1'b1;
  assign w_idx_nxt   = r_idx + 2'd1;
  // Slot 0 lives at C_SQ_BASE, each slot is 16 bytes (four 32-bit words)
  assign w_slot_base = C_SQ_BASE + AW'({r_tail[P-2:0], 4'b0000});
  assign w_new_head  = m_axi_rdata[P-1:0];
  assign w_new_level = r_tail - w_new_head;
  assign w_r_fire    = (r_state == HEAD_R) && m_axi_rvalid && m_axi_rready;
  assign w_bad_b     = m_axi_bready && m_axi_bvalid && (m_axi_bresp != 2'b00);
  assign w_bad_r     = w_r_fire && (m_axi_rresp != 2'b00);
  // A head beyond the tail (more than DEPTH entries outstanding) is bogus
  assign w_bad_head  = w_r_fire && (w_new_level > DEPTH_P);
  assign w_aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_w_done    = !m_axi_wvalid || m_axi_wready;
  assign w_unused_rdata = ^m_axi_rdata;

  assign sq_level    = r_tail - r_head;
  assign sq_full     = (sq_level == DEPTH_P);
  assign err         = r_err;
  assign m_axi_wstrb = 4'hF;
  // r_rdy_en keeps cmd_ready low until the first clock after reset release
  assign cmd_ready   = r_rdy_en && (r_state == IDLE) && !sq_full && !r_head_pend;

  // Main sequencer: ring writes, doorbell, head refresh, with registered AXI outputs
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= IDLE;
      r_tail        <= '0;
      r_head        <= '0;
      r_idx         <= '0;
      r_cmd         <= '0;
      r_irq_q       <= 1'b0;
      r_head_pend   <= 1'b0;
      r_err         <= 1'b0;
      r_rdy_en      <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      r_irq_q  <= irq_cq;
      r_rdy_en <= 1'b1;
      // A new edge always wins over the clear so a back-to-back irq is not lost
      if (w_irq_edge)
        r_head_pend <= 1'b1;
      else if (w_r_fire)
        r_head_pend <= 1'b0;
      if (w_bad_b || w_bad_r || w_bad_head)
        r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_head_pend) begin
            m_axi_araddr  <= C_SQ_HEAD_ADDR;
            m_axi_arvalid <= 1'b1;
            r_state       <= HEAD_AR;
          end else if (cmd_valid && cmd_ready) begin
            r_cmd         <= cmd_data;
            r_idx         <= 2'd0;
            m_axi_awaddr  <= w_slot_base;
            m_axi_wdata   <= cmd_data[31:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            r_state       <= WR_SLOT;
          end
        end
        WR_SLOT, DOORBELL: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            m_axi_bready <= 1'b1;
            r_state      <= (r_state == WR_SLOT) ? WR_RESP : DB_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready  <= 1'b0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            if (r_idx != 2'd3) begin
              r_idx        <= w_idx_nxt;
              m_axi_awaddr <= w_slot_base + AW'({w_idx_nxt, 2'b00});
              m_axi_wdata  <= r_cmd[{w_idx_nxt, 5'b00000} +: 32];
              r_state      <= WR_SLOT;
            end else begin
              r_tail       <= w_tail_nxt;
              m_axi_awaddr <= C_SQ_TAIL_ADDR;
              m_axi_wdata  <= 32'(w_tail_nxt);
              r_state      <= DOORBELL;
            end
          end
        end
        DB_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            r_state      <= IDLE;
          end
        end
        HEAD_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= HEAD_R;
          end
        end
        HEAD_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            // A bad rresp still loads; only an impossible head is dropped
            if (!w_bad_head) r_head <= w_new_head;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CMD_QUEUE_PRODUCER_ERR_CNT_EN
  logic [1:0] w_err_inc;
  logic [8:0] w_err_sum;
  logic [7:0] r_err_count;

  // A single read can carry two error events (bad rresp and bad head)
  assign w_err_inc = {1'b0, w_bad_b} + {1'b0, w_bad_r} + {1'b0, w_bad_head};
  assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};

  // Saturating error event counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      r_err_count <= 8'h00;
    else if (w_err_sum[8])
      r_err_count <= 8'hFF;
    else
      r_err_count <= w_err_sum[7:0];
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue_producer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_queue_producer
//  Purpose  : Self-checking bench for cmd_queue_producer with an AXI4-Lite
//             slave responder and a ring-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_queue_producer;

  localparam int AW = 12;

`ifdef CMD_QUEUE_PRODUCER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [127:0]  cmd_data = '0;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          irq_cq = 1'b0;
  logic          sq_full;
  logic [4:0]    sq_level;
  logic          err;
  logic [7:0]    err_count;

  always #5 aclk = ~aclk;

  cmd_queue_producer dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .irq_cq(irq_cq),
    .sq_full(sq_full), .sq_level(sq_level), .err(err), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs and observations
  int            aw_delay = 0;
  int            w_delay = 0;
  int            bad_b_at = -1;
  int            b_total = 0;
  int            r_total = 0;
  logic [31:0]   rd_val = '0;
  logic [1:0]    rd_resp = 2'b00;
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int            aw_len[$];
  int            w_len[$];

  // Reference model: ring pointers as plain integers modulo 32
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  int            tail_m = 0;
  int            head_m = 0;
  int            errcnt_m = 0;
  bit            err_m = 1'b0;

  function automatic int level_m();
    return (tail_m - head_m + 32) % 32;
  endfunction

  // Expected bus traffic for one command: four slot words then the doorbell
  task automatic model_cmd(input logic [127:0] d);
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(AW'(32'h100 + (tail_m % 16) * 16 + i * 4));
      exp_data.push_back(d[i*32 +: 32]);
    end
    tail_m = (tail_m + 1) % 32;
    exp_addr.push_back(AW'(0));
    exp_data.push_back(32'(tail_m));
  endtask

  task automatic model_reset();
    tail_m = 0; head_m = 0; errcnt_m = 0; err_m = 1'b0;
    exp_addr.delete(); exp_data.delete();
    obs_addr.delete(); obs_data.delete();
  endtask

  // AXI4-Lite slave: decisions at negedge, handshakes take effect at posedge
  initial begin
    bit f_aw, f_w, f_b, f_ar, f_r, have_aw, have_w, have_ar;
    int aw_wait, w_wait, aw_cyc, w_cyc;
    logic [AW-1:0] a_lat;
    logic [31:0]   d_lat;
    f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
    have_aw = 0; have_w = 0; have_ar = 0;
    aw_wait = 0; w_wait = 0; aw_cyc = 0; w_cyc = 0; a_lat = '0; d_lat = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_wait = 0; w_wait = 0; aw_cyc = 0; w_cyc = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        continue;
      end
      if (f_aw) begin have_aw = 1; m_axi_awready = 0; aw_wait = 0; aw_len.push_back(aw_cyc); aw_cyc = 0; end
      if (f_w)  begin have_w = 1;  m_axi_wready = 0;  w_wait = 0;  w_len.push_back(w_cyc);   w_cyc = 0;  end
      if (f_b)  m_axi_bvalid = 0;
      if (f_ar) begin have_ar = 1; m_axi_arready = 0; end
      if (f_r)  begin m_axi_rvalid = 0; r_total++; end
      if (have_aw && have_w && !m_axi_bvalid) begin
        obs_addr.push_back(a_lat);
        obs_data.push_back(d_lat);
        m_axi_bresp  = (b_total == bad_b_at) ? 2'b10 : 2'b00;
        m_axi_bvalid = 1;
        b_total++;
        have_aw = 0; have_w = 0;
      end
      if (m_axi_awvalid && !have_aw) begin
        aw_cyc++;
        if (aw_wait >= aw_delay) m_axi_awready = 1;
        else begin m_axi_awready = 0; aw_wait++; end
      end
      if (m_axi_wvalid && !have_w) begin
        w_cyc++;
        if (w_wait >= w_delay) m_axi_wready = 1;
        else begin m_axi_wready = 0; w_wait++; end
      end
      if (m_axi_arvalid && !have_ar) m_axi_arready = 1;
      if (have_ar && !m_axi_rvalid) begin
        m_axi_rvalid = 1; m_axi_rdata = rd_val; m_axi_rresp = rd_resp; have_ar = 0;
      end
      f_aw = m_axi_awready && m_axi_awvalid;
      if (f_aw) a_lat = m_axi_awaddr;
      f_w  = m_axi_wready && m_axi_wvalid;
      if (f_w) d_lat = m_axi_wdata;
      f_b  = m_axi_bvalid && m_axi_bready;
      f_ar = m_axi_arready && m_axi_arvalid;
      f_r  = m_axi_rvalid && m_axi_rready;
    end
  end

  task automatic send_cmd(input logic [127:0] d, output bit ok);
    ok = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_data = d;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge aclk);
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_writes(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (obs_addr.size() >= exp_addr.size()) begin ok = 1; break; end
      @(negedge aclk);
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic irq_pulse(output bit ok);
    int rt;
    rt = r_total; ok = 0;
    @(negedge aclk); irq_cq = 1'b1;
    @(negedge aclk); irq_cq = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (r_total > rt) begin ok = 1; break; end
      @(negedge aclk);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_valids got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata} !== '0 || m_axi_wstrb !== 4'hF) begin
      errors++; $display("FAIL reset_bus got aw=%h ar=%h wd=%h ws=%h want 0 0 0 f", m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb); end
    checks++; if ({cmd_ready, sq_full, sq_level, err, err_count} !== '0) begin
      errors++; $display("FAIL reset_status got rdy=%b full=%b lvl=%0d err=%b cnt=%0d want all 0", cmd_ready, sq_full, sq_level, err, err_count); end
    areset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_at_release got %b want 0", cmd_ready); end
    @(negedge aclk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    logic [127:0] d;
    bit ok;
    d = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    model_cmd(d);
    send_cmd(d, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout want handshake"); end
    wait_writes(ok);
    checks++; if (!ok || obs_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL single_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL single_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    checks++; if (sq_level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", sq_level); end
  endtask

  task automatic test_fill();
    logic [127:0] d;
    bit ok;
    int seen;
    logic [31:0] last_db;
    for (int n = 0; n < 15; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      d = {$urandom, $urandom, $urandom, $urandom};
      model_cmd(d);
      send_cmd(d, ok);
      wait_writes(ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_cmd%0d got timeout want writes", n); end
    end
    checks++; if (obs_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL fill_count got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL fill_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    last_db = (obs_data.size() > 0) ? obs_data[obs_data.size()-1] : 32'hFFFF_FFFF;
    checks++; if (last_db !== 32'h10) begin errors++; $display("FAIL fill_doorbell got %h want 10", last_db); end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    checks++; if (sq_full !== 1'b1 || sq_level !== 5'd16 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_status got full=%b lvl=%0d rdy=%b want 1 16 0", sq_full, sq_level, cmd_ready); end
    // A 17th command must be held off
    seen = 0;
    @(negedge aclk); cmd_valid = 1'b1; cmd_data = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (m_axi_awvalid || cmd_ready) seen++;
    end
    cmd_valid = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL full_hold got %0d active cycles want 0", seen); end
  endtask

  task automatic test_head();
    logic [127:0] d;
    bit ok;
    aw_delay = 0; w_delay = 0;
    rd_val = 32'h0000_0004; rd_resp = 2'b00;
    irq_pulse(ok);
    head_m = 4;
    checks++; if (!ok) begin errors++; $display("FAIL head_read got timeout want read"); end
    checks++; if (sq_full !== 1'b0 || sq_level !== 5'd12) begin
      errors++; $display("FAIL head_level got full=%b lvl=%0d want 0 12", sq_full, sq_level); end
    d = {$urandom, $urandom, $urandom, $urandom};
    model_cmd(d);
    send_cmd(d, ok);
    wait_writes(ok);
    checks++; if (obs_addr.size() != 5 || obs_addr[0] !== 12'h100 || obs_data[4] !== 32'h11) begin
      errors++; $display("FAIL head_next got n=%0d a0=%h db=%h want 5 100 11", obs_addr.size(),
                         (obs_addr.size() > 0) ? obs_addr[0] : '1, (obs_data.size() > 4) ? obs_data[4] : '1); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL head_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_delay();
    logic [127:0] d;
    bit ok;
    int b0;
    aw_delay = 3; w_delay = 0;
    aw_len.delete(); w_len.delete();
    b0 = b_total;
    d = {$urandom, $urandom, $urandom, $urandom};
    model_cmd(d);
    send_cmd(d, ok);
    wait_writes(ok);
    checks++; if (b_total - b0 != 5 || aw_len.size() != 5 || w_len.size() != 5) begin
      errors++; $display("FAIL delay_counts got b=%0d aw=%0d w=%0d want 5 5 5", b_total - b0, aw_len.size(), w_len.size()); end
    for (int i = 0; i < aw_len.size() && i < w_len.size(); i++) begin
      checks++; if (aw_len[i] != 4 || w_len[i] != 1) begin
        errors++; $display("FAIL delay_valid%0d got aw=%0d w=%0d want 4 1", i, aw_len[i], w_len[i]); end
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL delay_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    aw_delay = 0;
  endtask

  task automatic test_err();
    logic [127:0] d;
    bit ok;
    bad_b_at = b_total + 2;
    d = {$urandom, $urandom, $urandom, $urandom};
    model_cmd(d);
    err_m = 1'b1; errcnt_m = errcnt_m + 1;
    send_cmd(d, ok);
    wait_writes(ok);
    bad_b_at = -1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b want 1", err); end
    checks++; if (err_count !== (CNT_EN ? 8'(errcnt_m) : 8'h00)) begin
      errors++; $display("FAIL err_count got %0d want %0d", err_count, CNT_EN ? errcnt_m : 0); end
    checks++; if (obs_addr.size() != exp_addr.size()) begin
      errors++; $display("FAIL err_complete got %0d writes want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL err_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
  endtask

  task automatic test_random();
    logic [127:0] d;
    logic [4:0] nh;
    bit ok, inv;
    int ev, lvl;
    for (int it = 0; it < 24; it++) begin
      lvl = level_m();
      aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
      if (lvl == 16 || $urandom_range(0, 3) == 0) begin
        inv = ($urandom_range(0, 5) == 0);
        if (inv) nh = 5'(tail_m + int'($urandom_range(1, 15)));
        else     nh = 5'(head_m + int'($urandom_range(0, lvl)));
        rd_resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        rd_val  = {27'($urandom), nh};
        irq_pulse(ok);
        if (!inv) head_m = int'(nh);
        ev = int'(inv) + int'(rd_resp != 2'b00);
        if (ev != 0) err_m = 1'b1;
        errcnt_m = (errcnt_m + ev > 255) ? 255 : errcnt_m + ev;
        checks++; if (!ok || sq_level !== 5'(level_m()) || err !== err_m) begin
          errors++; $display("FAIL rand_head%0d got lvl=%0d err=%b want %0d %b", it, sq_level, err, level_m(), err_m); end
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        model_cmd(d);
        send_cmd(d, ok);
        wait_writes(ok);
        checks++; if (obs_addr.size() != exp_addr.size() || sq_level !== 5'(level_m())) begin
          errors++; $display("FAIL rand_cmd%0d got n=%0d lvl=%0d want %0d %0d", it, obs_addr.size(), sq_level, exp_addr.size(), level_m()); end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
          checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL rand_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
        end
        exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
      end
    end
    rd_resp = 2'b00;
    checks++; if (err_count !== (CNT_EN ? 8'(errcnt_m) : 8'h00)) begin
      errors++; $display("FAIL rand_errcnt got %0d want %0d", err_count, CNT_EN ? errcnt_m : 0); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    bit ok, hit;
    aw_delay = 0; w_delay = 0;
    if (level_m() == 16) begin
      rd_val = 32'(tail_m % 32); rd_resp = 2'b00;
      irq_pulse(ok);
      head_m = tail_m;
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    send_cmd(d, ok);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_axi_bready) begin hit = 1; break; end
      @(negedge aclk);
    end
    areset = 1'b1;
    #1;
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_wrresp got timeout want bready"); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0
                  || sq_level !== 5'd0 || cmd_ready !== 1'b0 || err !== 1'b0 || err_count !== 8'h00) begin
      errors++; $display("FAIL rstmid_state got v=%b lvl=%0d rdy=%b err=%b cnt=%0d want 0 0 0 0 0",
                         {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, sq_level, cmd_ready, err, err_count); end
    model_reset();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    d = {$urandom, $urandom, $urandom, $urandom};
    model_cmd(d);
    send_cmd(d, ok);
    wait_writes(ok);
    checks++; if (obs_addr.size() != 5 || obs_addr[0] !== 12'h100 || obs_data[4] !== 32'h1) begin
      errors++; $display("FAIL rstmid_next got n=%0d a0=%h db=%h want 5 100 1", obs_addr.size(),
                         (obs_addr.size() > 0) ? obs_addr[0] : '1, (obs_data.size() > 4) ? obs_data[4] : '1); end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL rstmid_wr%0d got %h=%h want %h=%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (sq_level !== 5'd1) begin errors++; $display("FAIL rstmid_level got %0d want 1", sq_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_head();
    test_delay();
    test_err();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cmd_queue_producer.md
CMD_QUEUE_PRODUCER -- requirements
Module: cmd_queue_producer

Interface
REQ-001 The block SHALL have parameter C_M_ADDR_WIDTH, default 12: AXI4-Lite master address width.
REQ-002 The block SHALL have parameter C_SQ_BASE, default 12'h100: byte offset of SQ ring slot 0.
REQ-003 The block SHALL have parameter C_SQ_DEPTH, default 16: ring slots, power of two, 2..256.
REQ-004 The block SHALL have parameter C_SQ_TAIL_ADDR, default 12'h000: tail doorbell register offset.
REQ-005 The block SHALL have parameter C_SQ_HEAD_ADDR, default 12'h004: consumer head register offset.
REQ-006 The block SHALL have port aclk, input, 1 bit: single clock, all logic on its rising edge.
REQ-007 The block SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_data in 128: command stream, 4 words, word0 = bits [31:0].
REQ-009 The block SHALL have AXI4-Lite master ports m_axi_aw*/w*/b*/ar*/r*: awaddr, araddr C_M_ADDR_WIDTH; wdata, rdata 32; wstrb 4; bresp, rresp 2.
REQ-010 The block SHALL have port irq_cq, input, 1 bit: completion interrupt from the command queue, level.
REQ-011 The block SHALL have ports sq_full out 1, sq_level out log2(C_SQ_DEPTH)+1, err out 1, err_count out 8.

Function
REQ-012 The block SHALL keep tail and head pointers of width P = log2(C_SQ_DEPTH)+1, where the MSB is the wrap bit, and SHALL set sq_level = tail - head (mod 2^P) and sq_full = (sq_level == C_SQ_DEPTH).
REQ-013 The FSM SHALL have states IDLE, WR_SLOT, WR_RESP, DOORBELL, DB_RESP, HEAD_AR, HEAD_R.
REQ-014 In IDLE, cmd_ready SHALL be 1 only if !sq_full and no head refresh is pending; a handshake SHALL capture cmd_data, set word index to 0 and go to WR_SLOT.
REQ-015 In WR_SLOT the block SHALL assert awvalid and wvalid together, with awaddr = C_SQ_BASE + tail[P-2:0]*16 + idx*4, wdata = the selected word and wstrb = 4'hF.
REQ-016 Each valid SHALL drop independently once its own handshake completes; after both complete the FSM SHALL go to WR_RESP with bready = 1.
REQ-017 On bvalid in WR_RESP, if idx < 3 the FSM SHALL increment idx and return to WR_SLOT; otherwise tail SHALL increment and the FSM SHALL go to DOORBELL.
REQ-018 DOORBELL SHALL write the new tail, zero-extended, to C_SQ_TAIL_ADDR under the same handshake rules; DB_RESP SHALL wait for bvalid and then return to IDLE.
REQ-019 A rising edge of irq_cq SHALL set head_pend; the edge SHALL be detected against a registered copy of irq_cq.
REQ-020 An irq_cq edge arriving while head_pend is already set SHALL be merged into it, not counted separately.
REQ-021 In IDLE with head_pend set, head_pend SHALL take priority over a new command and the FSM SHALL go to HEAD_AR.
REQ-022 HEAD_AR SHALL assert arvalid with araddr = C_SQ_HEAD_ADDR until arready; HEAD_R SHALL assert rready, load head = rdata[P-1:0] on rvalid, clear head_pend and return to IDLE.
REQ-023 head_pend SHALL be cleared on the rvalid cycle unless a new irq_cq edge occurs in that same cycle, in which case it SHALL stay set.
REQ-024 A bresp or rresp other than 2'b00 SHALL set err (sticky until reset); the sequence SHALL continue unchanged, and on a bad rresp head SHALL still load.
REQ-025 A read head that would give sq_level > C_SQ_DEPTH SHALL be discarded, head SHALL be kept, and err SHALL be set.
REQ-026 Pointers SHALL wrap modulo 2^P; slot index tail[P-2:0] SHALL wrap from C_SQ_DEPTH-1 to 0.
REQ-027 bready SHALL be 1 only in WR_RESP and DB_RESP, and rready SHALL be 1 only in HEAD_R.

Reset
REQ-028 While areset is high, the FSM SHALL be in IDLE, and tail, head, idx, head_pend and err SHALL be 0.
REQ-029 While areset is high, all AXI valid and ready outputs SHALL be 0, awaddr, araddr and wdata SHALL be 0, and wstrb SHALL be 4'hF.
REQ-030 While areset is high, cmd_ready SHALL be 0, sq_full SHALL be 0, sq_level SHALL be 0 and err_count SHALL be 0.
REQ-031 A reset asserted mid-transaction SHALL abandon the command immediately, with no resumption or retry after release.
REQ-032 cmd_ready SHALL first rise in the cycle after areset deasserts.

Configuration
REQ-033 With macro CMD_QUEUE_PRODUCER_ERR_CNT_EN defined, err_count SHALL increment on each error event of REQ-024 and REQ-025 and saturate at 8'hFF.
REQ-034 Without CMD_QUEUE_PRODUCER_ERR_CNT_EN, err_count SHALL be tied to 8'h00 and no counter logic SHALL be present; err SHALL be unaffected in both cases.

Verification
REQ-035 The bench SHALL cover: one cmd, data 128'h4444_3333_2222_1111 with zero-wait AXI -> writes 0x100=1111, 0x104=2222, 0x108=3333, 0x10C=4444, then 0x000=1; sq_level=1.
REQ-036 The bench SHALL cover: 16 cmds with no irq_cq -> sq_full=1 and cmd_ready=0 after the 16th doorbell (data 0x10); the 17th is held.
REQ-037 The bench SHALL cover: full ring, irq_cq pulse with read head=4 -> sq_full=0 and sq_level=12; the next cmd writes slot 0 at 0x100, doorbell data 0x11.
REQ-038 The bench SHALL cover: awready delayed 3 cycles and wready delayed 0 -> wvalid drops after 1 cycle and awvalid holds 4 cycles; exactly one B per word.
REQ-039 The bench SHALL cover: bresp=2'b10 on word 2 -> err=1, err_count=1 (macro on) or 0 (macro off); the command still completes and the doorbell is written.
REQ-040 The bench SHALL cover: areset pulse in WR_RESP -> all valids 0 and tail=0; after release the next cmd targets 0x100.
